// File: rtl/bitmask_scanner.sv
`default_nettype none
// ============================================================================
// bitmask_scanner : serialises the positions of the set bits of a WIDTH-bit
//                   mask, one index per beat, in priority order.
// Revision        : 1.0
// ============================================================================
module bitmask_scanner #(
   parameter int WIDTH     = 16,
   parameter int IDX_W     = $clog2(WIDTH),
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] in_bitmask,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_zero,
   output logic [IDX_W:0]   out_cnt
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] mask_d;
   logic             zero_q;
   logic [IDX_W:0]   cnt_q;

   logic [IDX_W-1:0] w_idx;
   logic [IDX_W:0]   w_popcnt;
   logic             w_single;
   logic             w_accept;
   logic             w_load;
   logic [WIDTH-1:0] w_clr;

   if (MSB_FIRST) begin : g_msb_first
      always_comb begin
         w_idx = '0;
         for (int i = 0; i < WIDTH; i++) begin
            if (mask_q[i]) w_idx = IDX_W'(i);
         end
      end
   end else begin : g_lsb_first
      always_comb begin
         w_idx = '0;
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask_q[i]) w_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      w_popcnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_popcnt = w_popcnt + (IDX_W + 1)'(in_bitmask[i]);
      end
   end

   // x & (x-1) drops the lowest set bit; zero result means at most one bit set
   assign w_single = (mask_q != '0) &&
                     ((mask_q & (mask_q - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);

   assign w_clr    = {{(WIDTH-1){1'b0}}, 1'b1} << w_idx;
   assign mask_d   = mask_q & ~w_clr;

   assign out_val  = (state_q == SCAN);
   assign out_idx  = w_idx;
   assign out_last = zero_q | w_single;
   assign out_zero = zero_q;
   assign out_cnt  = cnt_q;

   assign w_accept = out_val & out_rdy;
   // out_rdy reaches in_rdy combinationally so consecutive masks stream bubble-free
   assign in_rdy   = rst_n & ((state_q == IDLE) | (w_accept & out_last));
   assign w_load   = in_val & in_rdy;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mask_q  <= '0;
         zero_q  <= 1'b0;
         cnt_q   <= '0;
      end else if (w_load) begin
         state_q <= SCAN;
         mask_q  <= in_bitmask;
         zero_q  <= ~|in_bitmask;
         cnt_q   <= w_popcnt;
      end else if (w_accept) begin
         mask_q <= mask_d;
         if (out_last) begin
            state_q <= IDLE;
            zero_q  <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bitmask_scanner.sv
`default_nettype none
// ============================================================================
// tb_bitmask_scanner : directed checks on 8-bit MSB-first, 16-bit LSB-first
//                      and 64-bit MSB-first scanner instances.
// Revision           : 1.0
// ============================================================================
module tb_bitmask_scanner;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 8-bit, MSB first
   logic       v8, r8, ov8, ordy8, last8, zero8;
   logic [7:0] m8;
   logic [2:0] idx8;
   logic [3:0] cnt8;
   // 16-bit, LSB first
   logic        v16, r16, ov16, ordy16, last16, zero16;
   logic [15:0] m16;
   logic [3:0]  idx16;
   logic [4:0]  cnt16;
   // 64-bit, MSB first
   logic        v64, r64, ov64, ordy64, last64, zero64;
   logic [63:0] m64;
   logic [5:0]  idx64;
   logic [6:0]  cnt64;

   int nassert = 0;
   int nfail   = 0;

   bitmask_scanner #(.WIDTH(8), .MSB_FIRST(1'b1)) u8 (
      .clk(clk), .rst_n(rst_n), .in_val(v8), .in_rdy(r8), .in_bitmask(m8),
      .out_val(ov8), .out_rdy(ordy8), .out_idx(idx8), .out_last(last8),
      .out_zero(zero8), .out_cnt(cnt8));

   bitmask_scanner #(.WIDTH(16), .MSB_FIRST(1'b0)) u16 (
      .clk(clk), .rst_n(rst_n), .in_val(v16), .in_rdy(r16), .in_bitmask(m16),
      .out_val(ov16), .out_rdy(ordy16), .out_idx(idx16), .out_last(last16),
      .out_zero(zero16), .out_cnt(cnt16));

   bitmask_scanner #(.WIDTH(64), .MSB_FIRST(1'b1)) u64 (
      .clk(clk), .rst_n(rst_n), .in_val(v64), .in_rdy(r64), .in_bitmask(m64),
      .out_val(ov64), .out_rdy(ordy64), .out_idx(idx64), .out_last(last64),
      .out_zero(zero64), .out_cnt(cnt64));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic beat8(input string tag, input int idx, input bit last, input int cnt);
      #1;
      chk({tag, " val"},  64'(ov8),   64'd1);
      chk({tag, " idx"},  64'(idx8),  64'(idx));
      chk({tag, " last"}, 64'(last8), 64'(last));
      chk({tag, " cnt"},  64'(cnt8),  64'(cnt));
   endtask

   initial begin
      rst_n = 1'b0;
      v8 = 1'b0;  m8 = '0;  ordy8 = 1'b1;
      v16 = 1'b0; m16 = '0; ordy16 = 1'b1;
      v64 = 1'b0; m64 = '0; ordy64 = 1'b1;

      // reset state
      cyc(); cyc();
      chk("rst val8",  64'(ov8),   64'd0);
      chk("rst rdy8",  64'(r8),    64'd0);
      chk("rst idx8",  64'(idx8),  64'd0);
      chk("rst last8", 64'(last8), 64'd0);
      chk("rst zero8", 64'(zero8), 64'd0);
      chk("rst cnt8",  64'(cnt8),  64'd0);
      chk("rst rdy16", 64'(r16),   64'd0);
      chk("rst cnt64", 64'(cnt64), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("post-rst rdy8",  64'(r8),  64'd1);
      chk("post-rst rdy64", 64'(r64), 64'd1);

      // 1010_0100 -> 7,5,2
      v8 = 1'b1; m8 = 8'hA4;
      cyc(); v8 = 1'b0;
      beat8("A4 b0", 7, 1'b0, 3);
      cyc(); beat8("A4 b1", 5, 1'b0, 3);
      cyc(); beat8("A4 b2", 2, 1'b1, 3);
      cyc(); #1;
      chk("A4 done val", 64'(ov8), 64'd0);
      chk("A4 done rdy", 64'(r8),  64'd1);

      // zero mask -> single flagged beat
      v8 = 1'b1; m8 = 8'h00;
      cyc(); v8 = 1'b0;
      beat8("Z b0", 0, 1'b1, 0);
      chk("Z zero", 64'(zero8), 64'd1);
      cyc(); #1;
      chk("Z done val", 64'(ov8), 64'd0);

      // backpressure on 1000_0001
      v8 = 1'b1; m8 = 8'h81;
      cyc(); v8 = 1'b0; ordy8 = 1'b0;
      beat8("BP hold0", 7, 1'b0, 2);
      chk("BP rdy", 64'(r8), 64'd0);
      cyc(); beat8("BP hold1", 7, 1'b0, 2);
      cyc(); beat8("BP hold2", 7, 1'b0, 2);
      cyc(); ordy8 = 1'b1;
      beat8("BP hold3", 7, 1'b0, 2);
      cyc(); beat8("BP b1", 0, 1'b1, 2);
      cyc(); #1;
      chk("BP done val", 64'(ov8), 64'd0);

      // back-to-back 0x03 then 0x80
      v8 = 1'b1; m8 = 8'h03;
      cyc(); m8 = 8'h80;
      beat8("B2B b0", 1, 1'b0, 2);
      chk("B2B rdy0", 64'(r8), 64'd0);
      cyc();
      beat8("B2B b1", 0, 1'b1, 2);
      chk("B2B rdy1", 64'(r8), 64'd1);
      cyc(); v8 = 1'b0;
      beat8("B2B b2", 7, 1'b1, 1);
      cyc(); #1;
      chk("B2B done val", 64'(ov8), 64'd0);

      // reset mid-scan of 0xFF
      v8 = 1'b1; m8 = 8'hFF;
      cyc(); v8 = 1'b0;
      beat8("RM b0", 7, 1'b0, 8);
      cyc(); beat8("RM b1", 6, 1'b0, 8);
      cyc(); rst_n = 1'b0;
      beat8("RM b2", 5, 1'b0, 8);
      chk("RM rdy in rst", 64'(r8), 64'd0);
      cyc(); rst_n = 1'b1; #1;
      chk("RM val", 64'(ov8),  64'd0);
      chk("RM rdy", 64'(r8),   64'd1);
      chk("RM cnt", 64'(cnt8), 64'd0);
      v8 = 1'b1; m8 = 8'h10;
      cyc(); v8 = 1'b0;
      beat8("RM new", 4, 1'b1, 1);
      cyc(); #1;
      chk("RM new done", 64'(ov8), 64'd0);

      // 16-bit LSB first: 0x8001 -> 0, 15
      v16 = 1'b1; m16 = 16'h8001;
      cyc(); v16 = 1'b0; #1;
      chk("L16 b0 idx",  64'(idx16),  64'd0);
      chk("L16 b0 last", 64'(last16), 64'd0);
      chk("L16 b0 cnt",  64'(cnt16),  64'd2);
      cyc(); #1;
      chk("L16 b1 idx",  64'(idx16),  64'd15);
      chk("L16 b1 last", 64'(last16), 64'd1);
      cyc(); #1;
      chk("L16 done", 64'(ov16), 64'd0);
      // 0x0110 -> 4, 8
      v16 = 1'b1; m16 = 16'h0110;
      cyc(); v16 = 1'b0; #1;
      chk("L16 c0 idx", 64'(idx16), 64'd4);
      cyc(); #1;
      chk("L16 c1 idx",  64'(idx16),  64'd8);
      chk("L16 c1 last", 64'(last16), 64'd1);

      // 64-bit all ones: 63..0, cnt 64
      v64 = 1'b1; m64 = '1;
      cyc(); v64 = 1'b0; #1;
      for (int k = 0; k < 64; k++) begin
         chk("W64 val",  64'(ov64),   64'd1);
         chk("W64 idx",  64'(idx64),  64'(63 - k));
         chk("W64 last", 64'(last64), 64'(k == 63));
         chk("W64 cnt",  64'(cnt64),  64'd64);
         cyc(); #1;
      end
      chk("W64 done", 64'(ov64), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

endmodule
`default_nettype wire
